// File: rtl/pipeline_hazard_unit.sv
// Hazard unit for a 5-stage MIPS-style pipeline: stalls, flushes and EX forwarding selects,
// driven by a small destination scoreboard that mirrors EX/MEM/WB.
module pipeline_hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_m_Rt_Rd,
  input  logic             id_m_R_31,
  input  logic             id_reg_write_enable,
  input  logic             id_m_dtlh_ALUPC8,
  input  logic             id_m_Rt2_imm,
  input  logic             id_mem_write_enable,
  input  logic [1:0]       id_jump_pre_Op,
  input  logic             ex_branch_taken,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef struct packed {
    logic [4:0] dst;
    logic       wen;
    logic       is_load;
    logic       is_branch;
    logic [4:0] rs;
    logic [4:0] rt;
  } ex_stage_t;

  typedef struct packed {
    logic [4:0] dst;
    logic       wen;
    logic       is_load;
  } mem_stage_t;

  // WB only ever forwards, so whether it came from a load no longer matters there
  typedef struct packed {
    logic [4:0] dst;
    logic       wen;
  } wb_stage_t;

  localparam int EX_W  = $bits(ex_stage_t);
  localparam int MEM_W = $bits(mem_stage_t);
  localparam int WB_W  = $bits(wb_stage_t);
  localparam ex_stage_t  EX_EMPTY  = ex_stage_t'({EX_W{1'b0}});
  localparam mem_stage_t MEM_EMPTY = mem_stage_t'({MEM_W{1'b0}});
  localparam wb_stage_t  WB_EMPTY  = wb_stage_t'({WB_W{1'b0}});
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [4:0] decode_dst(input logic r31, input logic rt_rd,
                                            input logic [4:0] rd, input logic [4:0] rt);
    logic [4:0] dst;
    if (r31) begin
      dst = 5'd31;
    end else if (rt_rd) begin
      dst = rd;
    end else begin
      dst = rt;
    end
    return dst;
  endfunction

  // A load sitting in MEM is never a forwarding source; load-use stalling already spaced it out
  function automatic logic [1:0] fwd_select(input logic [4:0] src, input mem_stage_t mem,
                                            input wb_stage_t wb);
    logic [1:0] sel;
    if (mem.wen && !mem.is_load && (mem.dst == src)) begin
      sel = 2'b10;
    end else if (wb.wen && (wb.dst == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  ex_stage_t  ex_r;
  mem_stage_t mem_r;
  wb_stage_t  wb_r;
  logic [CNT_W-1:0] stall_cycles_r;

  logic [4:0] id_dst_s;
  logic       id_wen_s;
  logic       uses_rs_s;
  logic       uses_rt_s;
  ex_stage_t  id_entry_s;
  logic       freeze_s;
  logic       load_use_s;
  logic       jr_hz_s;
  logic       br_s;
  logic       pc_write_s;
  logic       ifid_write_s;
  logic       ifid_flush_s;
  logic       idex_flush_s;
  logic       count_s;

  // Decode the ID instruction into its scoreboard entry and source usage
  always_comb begin
    id_dst_s   = decode_dst(id_m_R_31, id_m_Rt_Rd, id_rd, id_rt);
    id_wen_s   = id_reg_write_enable && (id_dst_s != 5'd0);
    uses_rs_s  = (id_jump_pre_Op != 2'd3);
    uses_rt_s  = (id_jump_pre_Op != 2'd3) && (!id_m_Rt2_imm || id_mem_write_enable);
    id_entry_s = EX_EMPTY;
    id_entry_s.dst       = id_dst_s;
    id_entry_s.wen       = id_wen_s;
    id_entry_s.is_load   = !id_m_dtlh_ALUPC8;
    id_entry_s.is_branch = (id_jump_pre_Op == 2'd2);
    id_entry_s.rs        = id_rs;
    id_entry_s.rt        = id_rt;
  end

  // Hazard detection and prioritised pipeline control
  always_comb begin
    freeze_s   = icache_stall | dcache_stall;
    load_use_s = ex_r.wen && ex_r.is_load &&
                 ((uses_rs_s && (ex_r.dst == id_rs)) || (uses_rt_s && (ex_r.dst == id_rt)));
    // jr/jalr read rs in ID, so they wait until the target can come forward out of MEM
    jr_hz_s    = (id_jump_pre_Op == 2'd1) &&
                 ((ex_r.wen && (ex_r.dst == id_rs)) ||
                  (mem_r.wen && mem_r.is_load && (mem_r.dst == id_rs)));
    br_s       = ex_branch_taken && ex_r.is_branch;
    if (freeze_s) begin
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      ifid_flush_s = 1'b0;
      idex_flush_s = 1'b0;
    end else if (br_s) begin
      pc_write_s   = 1'b1;
      ifid_write_s = 1'b1;
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b1;
    end else if (load_use_s || jr_hz_s) begin
      pc_write_s   = 1'b0;
      ifid_write_s = 1'b0;
      ifid_flush_s = 1'b0;
      idex_flush_s = 1'b1;
    end else if ((id_jump_pre_Op == 2'd1) || (id_jump_pre_Op == 2'd3)) begin
      pc_write_s   = 1'b1;
      ifid_write_s = 1'b1;
      ifid_flush_s = 1'b1;
      idex_flush_s = 1'b0;
    end else begin
      pc_write_s   = 1'b1;
      ifid_write_s = 1'b1;
      ifid_flush_s = 1'b0;
      idex_flush_s = 1'b0;
    end
    count_s = !pc_write_s || ifid_flush_s || idex_flush_s;
  end

  assign pc_write     = pc_write_s;
  assign ifid_write   = ifid_write_s;
  assign ifid_flush   = ifid_flush_s;
  assign idex_flush   = idex_flush_s;
  assign fwd_a        = fwd_select(ex_r.rs, mem_r, wb_r);
  assign fwd_b        = fwd_select(ex_r.rt, mem_r, wb_r);
  assign stall_cycles = stall_cycles_r;

  // Scoreboard advance; a freeze holds every stage, including a taken branch waiting in EX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_r  <= EX_EMPTY;
      mem_r <= MEM_EMPTY;
      wb_r  <= WB_EMPTY;
    end else if (!freeze_s) begin
      wb_r.dst      <= mem_r.dst;
      wb_r.wen      <= mem_r.wen;
      mem_r.dst     <= ex_r.dst;
      mem_r.wen     <= ex_r.wen;
      mem_r.is_load <= ex_r.is_load;
      ex_r          <= idex_flush_s ? EX_EMPTY : id_entry_s;
    end else begin
      ex_r  <= ex_r;
      mem_r <= mem_r;
      wb_r  <= wb_r;
    end
  end

  // Saturating count of lost cycles (stalls, freezes and flushes)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_r <= {CNT_W{1'b0}};
    end else if (count_s && (stall_cycles_r != CNT_MAX)) begin
      stall_cycles_r <= stall_cycles_r + CNT_ONE;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit; uses CNT_W=4 so counter saturation is reachable.
module tb_pipeline_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_m_Rt_Rd, id_m_R_31, id_reg_write_enable, id_m_dtlh_ALUPC8;
  logic       id_m_Rt2_imm, id_mem_write_enable;
  logic [1:0] id_jump_pre_Op;
  logic       ex_branch_taken, icache_stall, dcache_stall;
  logic       pc_write, ifid_write, ifid_flush, idex_flush;
  logic [1:0] fwd_a, fwd_b;
  logic [3:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_unit #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_m_Rt_Rd(id_m_Rt_Rd), .id_m_R_31(id_m_R_31),
    .id_reg_write_enable(id_reg_write_enable), .id_m_dtlh_ALUPC8(id_m_dtlh_ALUPC8),
    .id_m_Rt2_imm(id_m_Rt2_imm), .id_mem_write_enable(id_mem_write_enable),
    .id_jump_pre_Op(id_jump_pre_Op), .ex_branch_taken(ex_branch_taken),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ctrl vector is {pc_write, ifid_write, ifid_flush, idex_flush}
  task automatic check_ctrl(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, pc_write, ifid_write, ifid_flush, idex_flush}, {28'd0, exp});
  endtask

  task automatic check_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
    check(tag, {28'd0, fwd_a, fwd_b}, {28'd0, a, b});
  endtask

  task automatic check_cnt(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, stall_cycles}, {28'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic rt_rd, input logic r31, input logic rwe, input logic nonload,
                        input logic imm, input logic mwe, input logic [1:0] jop);
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_m_Rt_Rd = rt_rd; id_m_R_31 = r31; id_reg_write_enable = rwe;
    id_m_dtlh_ALUPC8 = nonload; id_m_Rt2_imm = imm; id_mem_write_enable = mwe;
    id_jump_pre_Op = jop;
    #1;
  endtask

  task automatic id_nop();                                   id_set(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0); endtask
  task automatic id_rtype(input logic [4:0] rd, rs, rt);      id_set(rs, rt, rd, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0); endtask
  task automatic id_load(input logic [4:0] rt, rs);           id_set(rs, rt, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0); endtask
  task automatic id_addi(input logic [4:0] rt, rs);           id_set(rs, rt, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0); endtask
  task automatic id_beq(input logic [4:0] rs, rt);            id_set(rs, rt, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2); endtask
  task automatic id_jal();                                   id_set(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3); endtask
  task automatic id_jr(input logic [4:0] rs);                 id_set(rs, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1); endtask

  initial begin
    rst = 1'b1;
    ex_branch_taken = 1'b0; icache_stall = 1'b0; dcache_stall = 1'b0;
    id_nop();
    #1;
    check_ctrl("reset_ctrl", 4'b1100);
    check_fwd("reset_fwd", 2'b00, 2'b00);
    check_cnt("reset_cnt", 4'd0);
    tick();
    rst = 1'b0;
    tick();

    // lw $8 ; add $9,$8,$10 -> one stall, then WB forward
    id_load(5'd8, 5'd1);            check_ctrl("lw_issue", 4'b1100);   tick();
    id_rtype(5'd9, 5'd8, 5'd10);    check_ctrl("load_use_stall", 4'b0001); tick();
    #1;                             check_ctrl("load_use_release", 4'b1100);
                                    check_cnt("load_use_cnt", 4'd1);   tick();
    id_nop();                       check_fwd("load_use_fwd", 2'b01, 2'b00); tick();

    // add $8 ; sub $9,$8,$8 -> MEM forwards both operands, no stall
    id_rtype(5'd8, 5'd1, 5'd2);     tick();
    id_rtype(5'd9, 5'd8, 5'd8);     check_ctrl("alu_no_stall", 4'b1100); tick();
    id_addi(5'd0, 5'd1);            check_fwd("mem_fwd_both", 2'b10, 2'b10); tick();
    id_rtype(5'd5, 5'd0, 5'd0);     tick();
    id_rtype(5'd8, 5'd1, 5'd2);     check_fwd("zero_reg_no_fwd", 2'b00, 2'b00); tick();

    // Two writers of $8 in MEM and WB: MEM wins
    id_rtype(5'd8, 5'd3, 5'd4);     tick();
    id_rtype(5'd7, 5'd8, 5'd6);     tick();
    id_load(5'd8, 5'd1);            check_fwd("mem_over_wb", 2'b10, 2'b00);
                                    check_ctrl("alu_after_fwd", 4'b1100); tick();
    // addi $8,$2 after lw $8: rt is only the destination, so no stall and no MEM-load forward
    id_addi(5'd8, 5'd2);            check_ctrl("imm_rt_unused", 4'b1100); tick();
    id_nop();                       check_fwd("no_mem_load_fwd", 2'b00, 2'b00); tick();
    check_cnt("cnt_after_fwd", 4'd1);

    // lw $8 ; beq ; jr $8 with the beq resolving taken: branch beats the jr hazard
    id_load(5'd8, 5'd1);            tick();
    id_beq(5'd2, 5'd3);             check_ctrl("beq_issue", 4'b1100);  tick();
    id_jr(5'd8);                    check_ctrl("jr_mem_load_stall", 4'b0001);
    ex_branch_taken = 1'b1; #1;     check_ctrl("branch_priority", 4'b1111); tick();
    id_nop();                       check_ctrl("taken_without_branch", 4'b1100);
                                    check_cnt("cnt_after_branch", 4'd2);
    ex_branch_taken = 1'b0;         tick();

    // jal then jr $31
    id_jal();                       check_ctrl("jal_squash", 4'b1110); tick();
    id_jr(5'd31);                   check_ctrl("jr_ex_stall", 4'b0001); tick();
    #1;                             check_ctrl("jr_resolves", 4'b1110); tick();
    id_beq(5'd1, 5'd2);             check_ctrl("beq_issue2", 4'b1100);
                                    check_cnt("cnt_after_jr", 4'd5);   tick();

    // Taken branch held in EX across a 5-cycle D-cache freeze
    id_nop();
    ex_branch_taken = 1'b1; dcache_stall = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      check_ctrl("dcache_freeze", 4'b0000);
      tick();
    end
    dcache_stall = 1'b0; #1;        check_ctrl("flush_on_release", 4'b1111);
                                    check_cnt("cnt_after_freeze", 4'd10); tick();
    ex_branch_taken = 1'b0; #1;     check_ctrl("after_release", 4'b1100);
                                    check_cnt("cnt_release_edge", 4'd11);

    // I-cache freeze pushes the 4-bit counter into saturation
    icache_stall = 1'b1; #1;        check_ctrl("icache_freeze", 4'b0000);
    for (int i = 0; i < 6; i++) tick();
    check_cnt("cnt_saturated", 4'd15);
    icache_stall = 1'b0;
    id_jal();                       check_ctrl("jal_after_sat", 4'b1110); tick();
    check_cnt("cnt_stays_sat", 4'd15);
    id_nop();                       tick();

    // Reset in the middle of a load-use stall
    id_load(5'd8, 5'd1);            tick();
    id_rtype(5'd9, 5'd8, 5'd10);    check_ctrl("pre_reset_stall", 4'b0001);
    #2 rst = 1'b1; #1;              check_ctrl("async_reset_ctrl", 4'b1100);
                                    check_cnt("async_reset_cnt", 4'd0);
                                    check_fwd("async_reset_fwd", 2'b00, 2'b00);
    rst = 1'b0; #1;                 check_ctrl("no_residual_stall", 4'b1100); tick();
                                    check_cnt("cnt_after_reset", 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
